image_streamer: RTL and testbench

IMAGE_STREAMER -- requirements
Module: image_streamer

---
 rtl/image_streamer_if.sv | 28 ++
 rtl/image_streamer.sv | 220 ++++++++++++++++++++++
 tb/tb_image_streamer.sv | 276 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/image_streamer_if.sv
// Pixel stream handshake bundle between the image streamer and its consumer.
// Source drives data/position/valid and the consumer returns ready.
interface image_streamer_if;
    logic signed [7:0] pix_data;
    logic              pix_valid;
    logic              pix_ready;
    logic [4:0]        pix_row;
    logic [4:0]        pix_col;
    logic              pix_last;

    modport master (
        output pix_data,
        output pix_valid,
        output pix_row,
        output pix_col,
        output pix_last,
        input  pix_ready
    );

    modport slave (
        input  pix_data,
        input  pix_valid,
        input  pix_row,
        input  pix_col,
        input  pix_last,
        output pix_ready
    );
endinterface

// File: rtl/image_streamer.sv
// Streams an IMG_W x IMG_H image from a synchronous ROM as a ready/valid pixel
// stream, throttling ROM reads so the output buffer can never overflow.
module image_streamer #(
    parameter int IMG_W      = 28,
    parameter int IMG_H      = 28,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    output logic [9:0]           rom_addr,
    input  logic signed [7:0]    rom_data,
    image_streamer_if.master     pix,
    output logic                 busy,
    output logic                 done
);

    localparam int NPIX      = IMG_W * IMG_H;
    localparam int PTR_W     = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W     = $clog2(FIFO_DEPTH + 1);
    localparam int ROM_LAT   = 2;

    localparam logic [10:0]      NPIX_W    = 11'(NPIX);
    localparam logic [10:0]      LAST_IDX  = 11'(NPIX - 1);
    localparam logic [4:0]       COL_MAX   = 5'(IMG_W - 1);
    localparam logic [CNT_W-1:0] DEPTH_W   = CNT_W'(FIFO_DEPTH);
    localparam logic [PTR_W-1:0] PTR_MAX   = PTR_W'(FIFO_DEPTH - 1);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t             state_reg, state_next;
    logic [10:0]        issued_reg;
    logic [9:0]         rom_addr_reg;
    logic [CNT_W-1:0]   occ_reg;
    logic [CNT_W-1:0]   fifo_cnt_reg;
    logic [PTR_W-1:0]   wr_ptr_reg, rd_ptr_reg;
    logic signed [7:0]  fifo_mem [FIFO_DEPTH];
    logic [10:0]        out_idx_reg;
    logic [4:0]         row_reg, col_reg;
    logic               done_reg;

    logic               issue;
    logic               push;
    logic               xfer;
    logic               last_xfer;
    logic               fifo_nonempty;

    assign fifo_nonempty = (fifo_cnt_reg != '0);
    assign xfer          = fifo_nonempty && pix.pix_ready;
    assign last_xfer     = xfer && (out_idx_reg == LAST_IDX);

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Occupancy covers the ROM pipeline plus the buffer, so capping it at
    // FIFO_DEPTH guarantees every captured word has a free buffer slot.
    always_comb begin
        state_next = state_reg;
        issue      = 1'b0;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    state_next = RUN;
                    issue      = 1'b1;
                end
            end
            RUN: begin
                if ((issued_reg < NPIX_W) && (occ_reg < DEPTH_W)) begin
                    issue = 1'b1;
                end
                if (last_xfer) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Address issue and occupancy tracking
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rom_addr_reg <= '0;
            issued_reg   <= '0;
        end else if (last_xfer) begin
            issued_reg   <= '0;
        end else if (issue) begin
            rom_addr_reg <= issued_reg[9:0];
            issued_reg   <= issued_reg + 11'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            occ_reg <= '0;
        end else begin
            case ({issue, xfer})
                2'b10:   occ_reg <= occ_reg + CNT_W'(1);
                2'b01:   occ_reg <= occ_reg - CNT_W'(1);
                default: occ_reg <= occ_reg;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Valid shift pipeline matching the ROM read latency
    // ------------------------------------------------------------------
    for (genvar gi = 0; gi < ROM_LAT; gi++) begin : g_vpipe
        logic v_reg;
        logic v_in;

        if (gi == 0) begin : g_head
            assign v_in = issue;
        end else begin : g_tail
            assign v_in = g_vpipe[gi-1].v_reg;
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                v_reg <= 1'b0;
            end else begin
                v_reg <= v_in;
            end
        end
    end

    assign push = g_vpipe[ROM_LAT-1].v_reg;

    // ------------------------------------------------------------------
    // Output buffer
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr_reg] <= rom_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= (wr_ptr_reg == PTR_MAX) ? '0 : wr_ptr_reg + PTR_W'(1);
            end
            if (xfer) begin
                rd_ptr_reg <= (rd_ptr_reg == PTR_MAX) ? '0 : rd_ptr_reg + PTR_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fifo_cnt_reg <= '0;
        end else begin
            case ({push, xfer})
                2'b10:   fifo_cnt_reg <= fifo_cnt_reg + CNT_W'(1);
                2'b01:   fifo_cnt_reg <= fifo_cnt_reg - CNT_W'(1);
                default: fifo_cnt_reg <= fifo_cnt_reg;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Output-side position counters and completion pulse
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_idx_reg <= '0;
            row_reg     <= '0;
            col_reg     <= '0;
        end else if (last_xfer) begin
            out_idx_reg <= '0;
            row_reg     <= '0;
            col_reg     <= '0;
        end else if (xfer) begin
            out_idx_reg <= out_idx_reg + 11'd1;
            if (col_reg == COL_MAX) begin
                col_reg <= '0;
                row_reg <= row_reg + 5'd1;
            end else begin
                col_reg <= col_reg + 5'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            done_reg <= 1'b0;
        end else begin
            done_reg <= last_xfer;
        end
    end

    // Buffer contents are not reset, so gate the data path while empty.
    assign pix.pix_data  = fifo_nonempty ? fifo_mem[rd_ptr_reg] : 8'sd0;
    assign pix.pix_valid = fifo_nonempty;
    assign pix.pix_row   = row_reg;
    assign pix.pix_col   = col_reg;
    assign pix.pix_last  = fifo_nonempty && (out_idx_reg == LAST_IDX);

    assign rom_addr = rom_addr_reg;
    assign busy     = (state_reg == RUN);
    assign done     = done_reg;

endmodule

// File: tb/tb_image_streamer.sv
// Directed bench for image_streamer: a ROM model feeds the DUT and a
// scoreboard queue filled at each frame start is checked on every transfer.
module tb_image_streamer;

    localparam int W = 28;
    localparam int H = 28;
    localparam int N = W * H;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic [9:0]        rom_addr;
    logic signed [7:0] rom_data;
    logic              busy;
    logic              done;

    image_streamer_if pif ();

    image_streamer #(
        .IMG_W      (W),
        .IMG_H      (H),
        .FIFO_DEPTH (4)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .rom_addr (rom_addr),
        .rom_data (rom_data),
        .pix      (pif.master),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;

    logic signed [7:0] rom_mem [1024];
    always @(posedge clk) rom_data <= rom_mem[rom_addr];

    typedef struct {
        logic [7:0] data;
        logic [4:0] row;
        logic [4:0] col;
        logic       last;
    } pix_t;

    pix_t exp_q[$];
    pix_t mon_e;
    pix_t held;
    bit   prev_stall = 1'b0;
    int   checks = 0;
    int   errors = 0;
    int   frame_xfers = 0;
    int   done_count = 0;
    int   cyc;
    int   dc;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic push_frame();
        for (int i = 0; i < N; i++) begin
            pix_t p;
            p.data = 8'(i);
            p.row  = 5'(i / W);
            p.col  = 5'(i % W);
            p.last = (i == N - 1);
            exp_q.push_back(p);
        end
    endtask

    // Leaves the caller one time unit after the edge that sampled start.
    task automatic start_frame();
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        frame_xfers = 0;
        push_frame();
    endtask

    task automatic run_until_done(input int limit, input bit toggle, output int cycles);
        bit seen;
        seen   = 1'b0;
        cycles = 0;
        while (!seen && cycles < limit) begin
            @(negedge clk);
            cycles++;
            if (done) begin
                seen = 1'b1;
            end else begin
                @(posedge clk);
                #1;
                if (toggle) pif.pix_ready = ~pif.pix_ready;
            end
        end
        chk("done_timeout", 32'(seen), 1);
    endtask

    task automatic wait_xfers(input int n);
        int k;
        k = 0;
        while (frame_xfers < n && k < 3000) begin
            @(posedge clk);
            #1;
            k++;
        end
        chk("reach_xfers", 32'(frame_xfers >= n), 1);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_rom_addr"}, 32'(rom_addr), 0);
        chk({tag, "_pix_valid"}, 32'(pif.pix_valid), 0);
        chk({tag, "_pix_data"}, 32'($unsigned(pif.pix_data)), 0);
        chk({tag, "_pix_row"}, 32'(pif.pix_row), 0);
        chk({tag, "_pix_col"}, 32'(pif.pix_col), 0);
        chk({tag, "_pix_last"}, 32'(pif.pix_last), 0);
        chk({tag, "_busy"}, 32'(busy), 0);
        chk({tag, "_done"}, 32'(done), 0);
    endtask

    // Output monitor: scoreboard pop, hold-under-backpressure, occupancy bound.
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_stall = 1'b0;
        end else begin
            if (busy) chk("occupancy_le_4", 32'((int'(rom_addr) + 1 - frame_xfers) <= 4), 1);
            if (prev_stall) begin
                chk("hold_valid", 32'(pif.pix_valid), 1);
                chk("hold_data", 32'($unsigned(pif.pix_data)), 32'(held.data));
                chk("hold_row", 32'(pif.pix_row), 32'(held.row));
                chk("hold_col", 32'(pif.pix_col), 32'(held.col));
                chk("hold_last", 32'(pif.pix_last), 32'(held.last));
            end
            if (pif.pix_valid && pif.pix_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_pixel", 1, 0);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("pix_data", 32'($unsigned(pif.pix_data)), 32'(mon_e.data));
                    chk("pix_row", 32'(pif.pix_row), 32'(mon_e.row));
                    chk("pix_col", 32'(pif.pix_col), 32'(mon_e.col));
                    chk("pix_last", 32'(pif.pix_last), 32'(mon_e.last));
                end
                frame_xfers++;
            end
            prev_stall = pif.pix_valid && !pif.pix_ready;
            held.data  = $unsigned(pif.pix_data);
            held.row   = pif.pix_row;
            held.col   = pif.pix_col;
            held.last  = pif.pix_last;
            if (done) begin
                done_count++;
                chk("done_busy_low", 32'(busy), 0);
            end
        end
    end

    initial begin
        for (int i = 0; i < 1024; i++) rom_mem[i] = 8'(i);
        pif.pix_ready = 1'b1;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk_all_zero("reset");
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("idle_no_valid", 32'(pif.pix_valid), 0);
        chk("idle_not_busy", 32'(busy), 0);

        // Full frame with ready held high
        start_frame();
        chk("f1_addr0", 32'(rom_addr), 0);
        chk("f1_busy", 32'(busy), 1);
        run_until_done(2000, 1'b0, cyc);
        chk("f1_cycles", 32'(cyc), 787);
        chk("f1_queue_empty", 32'(exp_q.size()), 0);
        @(posedge clk);
        #1;
        chk("f1_done_one_cycle", 32'(done), 0);

        // Backpressure: ready low for 20 cycles from the first valid
        pif.pix_ready = 1'b0;
        start_frame();
        chk("lat_e0_valid", 32'(pif.pix_valid), 0);
        @(posedge clk);
        #1;
        chk("lat_e1_valid", 32'(pif.pix_valid), 0);
        @(posedge clk);
        #1;
        chk("lat_e2_valid", 32'(pif.pix_valid), 1);
        chk("lat_e2_data", 32'($unsigned(pif.pix_data)), 0);
        repeat (19) begin
            @(posedge clk);
            #1;
            chk("stall_data", 32'($unsigned(pif.pix_data)), 0);
            chk("stall_addr_le3", 32'(rom_addr <= 10'd3), 1);
        end
        chk("stall_addr_eq3", 32'(rom_addr), 3);
        pif.pix_ready = 1'b1;
        run_until_done(2000, 1'b0, cyc);
        chk("stall_queue_empty", 32'(exp_q.size()), 0);
        @(posedge clk);
        #1;

        // Ready toggling every cycle
        start_frame();
        run_until_done(4000, 1'b1, cyc);
        chk("toggle_cycles_range", 32'(cyc >= 1560 && cyc <= 1580), 1);
        chk("toggle_queue_empty", 32'(exp_q.size()), 0);
        @(posedge clk);
        #1;
        pif.pix_ready = 1'b1;

        // Start pulsed mid-frame is ignored
        start_frame();
        dc = done_count;
        wait_xfers(100);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        chk("midstart_busy", 32'(busy), 1);
        run_until_done(2000, 1'b0, cyc);
        repeat (3) @(posedge clk);
        #1;
        chk("midstart_single_done", 32'(done_count - dc), 1);
        chk("midstart_queue_empty", 32'(exp_q.size()), 0);

        // Reset mid-frame, then replay from address 0
        start_frame();
        wait_xfers(300);
        rst_n = 1'b0;
        #1;
        chk_all_zero("midrst");
        exp_q.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        frame_xfers = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("postrst_valid", 32'(pif.pix_valid), 0);
        chk("postrst_busy", 32'(busy), 0);
        start_frame();
        chk("replay_addr0", 32'(rom_addr), 0);
        run_until_done(2000, 1'b0, cyc);
        chk("replay_queue_empty", 32'(exp_q.size()), 0);

        // Back-to-back: start asserted in the done cycle
        @(posedge clk);
        #1;
        start_frame();
        run_until_done(2000, 1'b0, cyc);
        chk("b2b_first_empty", 32'(exp_q.size()), 0);
        start_frame();
        chk("b2b_addr0", 32'(rom_addr), 0);
        chk("b2b_busy", 32'(busy), 1);
        run_until_done(2000, 1'b0, cyc);

        repeat (3) @(posedge clk);
        #1;
        chk("final_queue_empty", 32'(exp_q.size()), 0);
        chk("done_total", 32'(done_count), 7);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
